// File: rtl/token_rx_assembler.sv
// token_rx_assembler: frames the unstuffed receive byte stream into packets,
// collects the three token bytes and presents a 24-bit token word with a
// one-cycle valid strobe plus per-packet error strobes.
//
// Input handshake: a byte is taken on any rising edge where
// i_rx_active=1 and i_rx_valid=1. There is no backpressure. i_rx_valid is
// ignored while i_rx_active=0. Output strobes last exactly one cycle.
// o_token_data is held between token strobes.
module token_rx_assembler #(
  parameter bit CHECK_CRC = 1'b1,
  parameter int MAX_BYTES = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_active,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_error,
  output logic [23:0] o_token_data,
  output logic        o_token_valid,
  output logic        o_pid_err,
  output logic        o_len_err,
  output logic        o_crc_err,
  output logic        o_busy,
  output logic [1:0]  o_state
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] C_MAX   = CW'(MAX_BYTES);
  localparam logic [CW-1:0] C_THREE = CW'(3);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHECK   = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_cnt;
  logic [23:0]    r_shift;
  logic [7:0]     r_pid;
  // Cleared by reset, set once rx_active has been seen low. Keeps the tail
  // of a packet that was interrupted by reset from being collected.
  logic           r_armed;
  logic [23:0]    r_token_data;
  logic           r_token_valid;
  logic           r_pid_err;
  logic           r_len_err;
  logic           r_crc_err;

  logic           w_accept;
  logic           w_start;
  logic           w_to_check;
  logic           w_cnt_zero;
  logic           w_pid_ok;
  logic           w_is_token;
  logic           w_crc_bad;
  logic           w_good;

  // CRC5 x^5+x^2+1, init 0, MSB first, no final inversion
  function automatic logic [4:0] f_crc5(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'b00000;
    for (int i = 10; i >= 0; i--) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b00101;
    end
    return c;
  endfunction

  assign w_accept   = i_rx_valid && i_rx_active;
  // A packet starts from IDLE (once armed) or directly out of CHECK when
  // rx_active re-rises in the CHECK cycle.
  assign w_start    = i_rx_active &&
                      ((r_state == S_IDLE && r_armed) || r_state == S_CHECK);
  assign w_to_check = (r_state == S_COLLECT) && !i_rx_error && !i_rx_active;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_pid_ok   = (r_pid[7:4] == ~r_pid[3:0]);
  assign w_is_token = (r_pid[3:0] == 4'b0001) || (r_pid[3:0] == 4'b1001) ||
                      (r_pid[3:0] == 4'b1101) || (r_pid[3:0] == 4'b0101);
  assign w_crc_bad  = CHECK_CRC && (f_crc5(r_shift[15:5]) != r_shift[4:0]);
  assign w_good     = !w_cnt_zero && w_pid_ok && w_is_token && (r_cnt == C_THREE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; an error in the very first cycle goes straight to DISCARD
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_CHECK: begin
        if (w_start)                   w_state_next = i_rx_error ? S_DISCARD : S_COLLECT;
        else if (r_state == S_CHECK)   w_state_next = S_IDLE;
      end
      S_COLLECT: begin
        if (i_rx_error)                w_state_next = S_DISCARD;
        else if (!i_rx_active)         w_state_next = S_CHECK;
      end
      S_DISCARD: begin
        if (!i_rx_active)              w_state_next = S_IDLE;
      end
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // Arming flag: re-armed by any cycle with rx_active low
  always_ff @(posedge i_clk) begin
    if (i_reset) r_armed <= 1'b0;
    else         r_armed <= r_armed | ~i_rx_active;
  end

  // Byte counter, shift register and captured PID byte
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_pid   <= '0;
    end else if (w_start) begin
      r_cnt   <= w_accept ? C_ONE : '0;
      r_shift <= w_accept ? {16'h0000, i_rx_data} : 24'h0;
      r_pid   <= w_accept ? i_rx_data : 8'h00;
    end else if (r_state == S_COLLECT && w_accept) begin
      if (r_cnt != C_MAX)  r_cnt   <= r_cnt + C_ONE;
      if (r_cnt < C_THREE) r_shift <= {r_shift[15:0], i_rx_data};
      if (w_cnt_zero)      r_pid   <= i_rx_data;
    end
  end

  // Packet evaluation, registered so the strobes land in the CHECK cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_token_data  <= 24'h0;
      r_token_valid <= 1'b0;
      r_pid_err     <= 1'b0;
      r_len_err     <= 1'b0;
      r_crc_err     <= 1'b0;
    end else begin
      r_token_valid <= 1'b0;
      r_pid_err     <= 1'b0;
      r_len_err     <= 1'b0;
      r_crc_err     <= 1'b0;
      if (w_to_check) begin
        r_pid_err     <= !w_cnt_zero && !w_pid_ok;
        r_len_err     <= !w_cnt_zero && w_pid_ok && w_is_token && (r_cnt != C_THREE);
        r_token_valid <= w_good;
        r_crc_err     <= w_good && w_crc_bad;
        if (w_good) r_token_data <= r_shift;
      end
    end
  end

  assign o_token_data  = r_token_data;
  assign o_token_valid = r_token_valid;
  assign o_pid_err     = r_pid_err;
  assign o_len_err     = r_len_err;
  assign o_crc_err     = r_crc_err;
  assign o_busy        = (r_state != S_IDLE);
  assign o_state       = r_state;

endmodule

// File: doc/token_rx_assembler.md
Name: token_rx_assembler

Overview:
- Upstream neighbour of the token decoder. Sits between the receive byte interface (after NRZI decode and bit-unstuffing) and the token decoder.
- Frames the byte stream into packets and collects exactly three bytes (PID, addr/endp high, endp low/CRC5).
- For every well-formed token packet, presents a 24-bit token word with a one-cycle valid strobe, plus per-packet error strobes.

Parameters:
- CHECK_CRC, 1, when 1 the CRC5 is checked here and crc_err is driven; when 0 crc_err is tied low.
- MAX_BYTES, 15, saturation value of the internal byte counter; must be ≥4.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- rx_active  in  1  high for the duration of one packet
- rx_valid  in  1  rx_data carries a byte this cycle; ignored when rx_active=0
- rx_data  in  8  received byte
- rx_error  in  1  PHY receive error; aborts the current packet
- token_data  out  24  {byte0, byte1, byte2}: [23:16]=PID, [15:9]=addr, [8:5]=endp, [4:0]=CRC5
- token_valid  out  1  one-cycle strobe; token_data is valid and held until the next strobe
- pid_err  out  1  one-cycle strobe: PID check nibble is bad
- len_err  out  1  one-cycle strobe: token PID but byte count ≠ 3
- crc_err  out  1  one-cycle strobe: CRC5 mismatch (CHECK_CRC=1 only)
- busy  out  1  high while a packet is being collected (state ≠ IDLE)

Behaviour:

Reset (synchronous):
- State goes to IDLE, byte counter to 0, shift register to 0.
- token_data = 24'h0. token_valid, pid_err, len_err, crc_err and busy are all 0.
- Reset mid-packet discards the packet with no strobes. The remainder of that packet is ignored until rx_active has been seen low.

State machine:
- IDLE: waits for rx_active=1 → COLLECT. A byte arriving in the same cycle rx_active rises is accepted.
- COLLECT: each rx_valid byte shifts into a 24-bit register (new byte enters [7:0]) for the first 3 bytes. The counter increments on every byte, saturating at MAX_BYTES.
  - rx_error=1 → DISCARD.
  - rx_active=0 → CHECK.
- CHECK: one cycle; evaluates the collected packet and issues at most one strobe group → IDLE.
- DISCARD: no strobes; waits for rx_active=0 → IDLE.

CHECK rules, evaluated in priority order:
1. Counter = 0: no strobe.
2. byte0[7:4] ≠ ~byte0[3:0]: pid_err.
3. byte0[3:0] not in {0001 OUT, 1001 IN, 1101 SETUP, 0101 SOF}: no strobe (data/handshake packets are not tokens).
4. Counter ≠ 3: len_err.
5. CHECK_CRC=1 and CRC5(word[15:5]) ≠ word[4:0]: crc_err, with token_valid and token_data still updated.
6. Otherwise token_valid only.

Token output and CRC:
- token_data updates in the same cycle as token_valid (registered, asserted in the CHECK cycle). It is unchanged by pid_err and len_err.
- CRC5: polynomial x^5+x^2+1, init 5'b00000, 11 data bits fed MSB first (word[15] first), no output inversion. This matches the downstream decoder.
- Latency: strobe is asserted exactly 1 cycle after the first cycle with rx_active=0 following the packet.

Boundary conditions:
- rx_active may re-rise in the CHECK cycle. That packet's first byte is accepted, since the return to IDLE and re-entry to COLLECT happen in the same edge.
- Bytes with rx_valid=0 are never counted.
- rx_error in the same cycle as the last byte → DISCARD wins.
- More than MAX_BYTES bytes: counter saturates and the result is still len_err.

Test Plan:
1. Reset, then rx_active for 3 cycles with bytes 69, 00, 00, then drop → 1 cycle later token_valid=1, token_data=24'h690000, all error strobes 0.
2. Bytes E1, 00, 01 (CRC field 00001) → token_valid=1 and crc_err=1 in the same cycle, token_data=24'hE10001. Repeat with CHECK_CRC=0 → crc_err stays 0.
3. Bytes 61, 00, 00 (bad check nibble) → pid_err=1, token_valid=0, token_data keeps the previous value 24'hE10001.
4. Bytes 2D, 00 (2 bytes) → len_err=1. Bytes 2D, 00, 00, 00 → len_err=1. Bytes C3, then 8 data bytes (DATA0) → no strobe at all.
5. rx_error asserted on byte 2 of A5, 00, 00 → no strobe; busy stays 1 until rx_active falls.
6. reset asserted between bytes 1 and 2 of IN packet 69, 00, 00 while rx_active stays high → no strobe for that packet. The next clean packet 69, 00, 00 → token_valid=1. Back-to-back packets with a single rx_active-low cycle between them → two token_valid strobes.
